// File: rtl/deparser_pkg.sv
// Shared widths, FSM encoding and action-word slot helpers for the deparser
// action sequencer.
package deparser_pkg;

  localparam int unsigned RAM_WIDTH = 384;
  localparam int unsigned ACT_W     = 16;
  localparam int unsigned N_ACTS    = RAM_WIDTH / ACT_W;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned IDX_W     = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_ISSUE,
    ST_POP
  } state_e;

  // Slot k sits at the top of the word: bits [RAM_WIDTH-1-ACT_W*k -: ACT_W].
  function automatic logic [ACT_W-1:0] slot_get(input logic [RAM_WIDTH-1:0] w,
                                                input logic [IDX_W-1:0]     k);
    return w[RAM_WIDTH - 1 - ACT_W * 32'(k) -: ACT_W];
  endfunction

  // The MSB of each slot is its enable.
  function automatic logic [N_ACTS-1:0] slot_en_mask(input logic [RAM_WIDTH-1:0] w);
    logic [N_ACTS-1:0] m;
    m = '0;
    for (int unsigned k = 0; k < N_ACTS; k++) begin
      m[k] = w[RAM_WIDTH - 1 - ACT_W * k];
    end
    return m;
  endfunction

endpackage

// File: rtl/deparser_slot_pick.sv
// Combinational priority picker: lowest enabled slot, and lowest enabled
// slot strictly above the current index.
module deparser_slot_pick
  import deparser_pkg::*;
(
  input  logic [N_ACTS-1:0] mask_i,
  input  logic [IDX_W-1:0]  cur_i,
  output logic [IDX_W-1:0]  first_c,
  output logic [IDX_W-1:0]  next_c,
  output logic              has_next_c,
  output logic              any_c
);

  // Scan high to low so the last hit is the lowest qualifying slot.
  always_comb begin
    first_c    = '0;
    next_c     = '0;
    has_next_c = 1'b0;
    for (int k = int'(N_ACTS) - 1; k >= 0; k--) begin
      if (mask_i[k]) begin
        first_c = IDX_W'(k);
        if (IDX_W'(k) > cur_i) begin
          next_c     = IDX_W'(k);
          has_next_c = 1'b1;
        end
      end
    end
  end

  assign any_c = |mask_i;

endmodule

// File: rtl/deparser_act_sequencer.sv
// Reads the action word addressed by the PHV at the FIFO head and issues its
// enabled 16-bit sub-actions over valid/ready, then pops the PHV.
module deparser_act_sequencer
  import deparser_pkg::*;
#(
  parameter int unsigned C_PARSER_RAM_WIDTH = RAM_WIDTH,
  parameter int unsigned C_PHV_WIDTH        = 1124,
  parameter int unsigned PHV_ADDR_LSB       = 0,
  parameter int unsigned ACT_WIDTH          = ACT_W,
  parameter int unsigned NUM_ACTS           = N_ACTS
) (
  input  logic                          axis_clk,
  input  logic                          aresetn,
  input  logic                          i_phv_fifo_empty_n,
  input  logic [C_PHV_WIDTH-1:0]        i_phv_fifo_data,
  output logic                          o_phv_fifo_rd_en,
  output logic [ADDR_W-1:0]             o_deparser_addrb,
  input  logic [C_PARSER_RAM_WIDTH-1:0] i_bram_out,
  output logic [C_PHV_WIDTH-1:0]        o_phv,
  output logic                          o_act_valid,
  output logic [ACT_WIDTH-1:0]          o_act_data,
  output logic [IDX_W-1:0]              o_act_idx,
  output logic                          o_act_last,
  input  logic                          i_act_ready,
  output logic                          o_busy
);

  state_e                        state_q, state_d;
  logic [C_PHV_WIDTH-1:0]        phv_q, phv_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [C_PARSER_RAM_WIDTH-1:0] act_q, act_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [ACT_WIDTH-1:0]          data_q, data_d;
  logic                          valid_q, valid_d;
  logic                          last_q, last_d;
  logic                          rd_en_q, rd_en_d;
  logic                          busy_q, busy_d;

  logic [NUM_ACTS-1:0] mask_c;
  logic [IDX_W-1:0]    first_c, next_c, first_b_c, next_b_c, look_cur_c;
  logic                has_next_c, any_c, look_has_next_c, any_b_c;

  // In RD2 the word is still on the RAM bus; afterwards it lives in act_q.
  assign mask_c = (state_q == ST_RD2) ? slot_en_mask(i_bram_out) : slot_en_mask(act_q);

  deparser_slot_pick u_pick_cur (
    .mask_i     (mask_c),
    .cur_i      (idx_q),
    .first_c    (first_c),
    .next_c     (next_c),
    .has_next_c (has_next_c),
    .any_c      (any_c)
  );

  // Lookahead on the slot about to be presented, to register o_act_last with it.
  assign look_cur_c = (state_q == ST_RD2) ? first_c : next_c;

  deparser_slot_pick u_pick_look (
    .mask_i     (mask_c),
    .cur_i      (look_cur_c),
    .first_c    (first_b_c),
    .next_c     (next_b_c),
    .has_next_c (look_has_next_c),
    .any_c      (any_b_c)
  );

  always_comb begin
    state_d = state_q;
    phv_d   = phv_q;
    addr_d  = addr_q;
    act_d   = act_q;
    idx_d   = idx_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    rd_en_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_phv_fifo_empty_n) begin
          phv_d   = i_phv_fifo_data;
          addr_d  = i_phv_fifo_data[PHV_ADDR_LSB +: ADDR_W];
          state_d = ST_RD0;
        end
      end
      ST_RD0: state_d = ST_RD1;
      ST_RD1: state_d = ST_RD2;
      ST_RD2: begin
        act_d = i_bram_out;
        if (any_c) begin
          state_d = ST_ISSUE;
          idx_d   = first_c;
          data_d  = slot_get(i_bram_out, first_c);
          valid_d = 1'b1;
          last_d  = ~look_has_next_c;
        end else begin
          state_d = ST_POP;
          rd_en_d = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (valid_q && i_act_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = ST_POP;
            rd_en_d = 1'b1;
          end else begin
            idx_d  = next_c;
            data_d = slot_get(act_q, next_c);
            last_d = ~look_has_next_c;
          end
        end
      end
      ST_POP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge axis_clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
      phv_q   <= '0;
      addr_q  <= '0;
      act_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phv_q   <= phv_d;
      addr_q  <= addr_d;
      act_q   <= act_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
    end
  end

  assign o_phv_fifo_rd_en = rd_en_q;
  assign o_deparser_addrb = addr_q;
  assign o_phv            = phv_q;
  assign o_act_valid      = valid_q;
  assign o_act_data       = data_q;
  assign o_act_idx        = idx_q;
  assign o_act_last       = last_q;
  assign o_busy           = busy_q;

endmodule

// File: tb/tb_deparser_act_sequencer.sv
// Directed bench for deparser_act_sequencer with a show-ahead FIFO model and
// a two-cycle-latency action RAM model.
module tb_deparser_act_sequencer;

  logic           axis_clk = 1'b0;
  logic           aresetn;
  logic           i_phv_fifo_empty_n;
  logic [1123:0]  i_phv_fifo_data;
  logic           o_phv_fifo_rd_en;
  logic [8:0]     o_deparser_addrb;
  logic [383:0]   i_bram_out;
  logic [1123:0]  o_phv;
  logic           o_act_valid;
  logic [15:0]    o_act_data;
  logic [4:0]     o_act_idx;
  logic           o_act_last;
  logic           i_act_ready;
  logic           o_busy;

  int checks = 0;
  int errors = 0;

  deparser_act_sequencer dut (
    .axis_clk           (axis_clk),
    .aresetn            (aresetn),
    .i_phv_fifo_empty_n (i_phv_fifo_empty_n),
    .i_phv_fifo_data    (i_phv_fifo_data),
    .o_phv_fifo_rd_en   (o_phv_fifo_rd_en),
    .o_deparser_addrb   (o_deparser_addrb),
    .i_bram_out         (i_bram_out),
    .o_phv              (o_phv),
    .o_act_valid        (o_act_valid),
    .o_act_data         (o_act_data),
    .o_act_idx          (o_act_idx),
    .o_act_last         (o_act_last),
    .i_act_ready        (i_act_ready),
    .o_busy             (o_busy)
  );

  always #5 axis_clk = ~axis_clk;

  // Action RAM: address registered, data out two cycles later.
  logic [383:0] mem [512];
  logic [383:0] ram_q1, ram_q2;
  always @(posedge axis_clk) begin
    ram_q1 <= mem[o_deparser_addrb];
    ram_q2 <= ram_q1;
  end
  assign i_bram_out = ram_q2;

  // Show-ahead PHV FIFO.
  logic [1123:0] fifo_mem [4];
  int wr_p = 0;
  int rd_p = 0;
  always @(posedge axis_clk) begin
    if (o_phv_fifo_rd_en) rd_p <= rd_p + 1;
  end
  assign i_phv_fifo_empty_n = (wr_p != rd_p);
  assign i_phv_fifo_data    = fifo_mem[rd_p[1:0]];

  task automatic push(input logic [1123:0] p);
    fifo_mem[wr_p[1:0]] = p;
    wr_p = wr_p + 1;
  endtask

  function automatic logic [383:0] put(input logic [383:0] w, input int k, input logic [15:0] v);
    logic [383:0] r;
    r = w;
    r[383 - 16 * k -: 16] = v;
    return r;
  endfunction

  function automatic logic [1123:0] mk_phv(input logic [8:0] a, input logic [23:0] tag);
    logic [1123:0] p;
    p = '0;
    p[1123:1100] = tag;
    p[8:0] = a;
    return p;
  endfunction

  // {addrb, valid, idx, data, last, rd_en, busy}; slot fields only matter while valid.
  function automatic logic [33:0] e(input logic [8:0] a, input logic v, input logic [4:0] i,
                                     input logic [15:0] d, input logic l, input logic r, input logic b);
    return {a, v, v ? i : 5'd0, v ? d : 16'd0, v ? l : 1'b0, r, b};
  endfunction

  function automatic logic [33:0] obs();
    return {o_deparser_addrb, o_act_valid, o_act_valid ? o_act_idx : 5'd0,
            o_act_valid ? o_act_data : 16'd0, o_act_valid ? o_act_last : 1'b0,
            o_phv_fifo_rd_en, o_busy};
  endfunction

  logic [383:0] w1, w_zero, w_a, w_b, w_new;

  task automatic test_reset();
    aresetn = 1'b0;
    i_act_ready = 1'b1;
    #1;
    checks++;
    if ({obs(), o_act_idx, o_act_data, o_act_last} !== {e(9'd0, 1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0), 22'd0})
      begin errors++; $display("FAIL reset_outputs got %h", obs()); end
    checks++;
    if (o_phv !== '0) begin errors++; $display("FAIL reset_phv got nonzero %h", o_phv[1123:1100]); end
    repeat (2) @(negedge axis_clk);
    aresetn = 1'b1;
    @(negedge axis_clk);
    checks++;
    if (obs() !== e(9'd0, 1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0))
      begin errors++; $display("FAIL reset_idle got %h", obs()); end
  endtask

  task automatic test_single();
    logic [33:0] ex [1:8];
    logic [1123:0] p;
    p = mk_phv(9'h005, 24'hABCDEF);
    for (int c = 1; c <= 3; c++) ex[c] = e(9'd5, 1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    ex[4] = e(9'd5, 1'b1, 5'd0,  16'h8A01, 1'b0, 1'b0, 1'b1);
    ex[5] = e(9'd5, 1'b1, 5'd3,  16'h8B03, 1'b0, 1'b0, 1'b1);
    ex[6] = e(9'd5, 1'b1, 5'd23, 16'h8C17, 1'b1, 1'b0, 1'b1);
    ex[7] = e(9'd5, 1'b0, 5'd0,  16'd0,    1'b0, 1'b1, 1'b1);
    ex[8] = e(9'd5, 1'b0, 5'd0,  16'd0,    1'b0, 1'b0, 1'b0);
    push(p);
    for (int c = 1; c <= 8; c++) begin
      @(negedge axis_clk);
      checks++;
      if (obs() !== ex[c]) begin errors++; $display("FAIL single cyc%0d got %h exp %h", c, obs(), ex[c]); end
    end
    checks++;
    if (o_phv !== p) begin errors++; $display("FAIL single_phv got %h exp %h", o_phv[1123:1100], p[1123:1100]); end
    checks++;
    if (i_phv_fifo_empty_n !== 1'b0) begin errors++; $display("FAIL single_popped got %b exp 0", i_phv_fifo_empty_n); end
  endtask

  task automatic test_backpressure();
    logic [33:0] ex [1:11];
    logic rdy [1:11];
    for (int c = 1; c <= 11; c++) rdy[c] = 1'b1;
    rdy[5] = 1'b0; rdy[6] = 1'b0; rdy[7] = 1'b0;
    for (int c = 1; c <= 3; c++) ex[c] = e(9'd5, 1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    ex[4] = e(9'd5, 1'b1, 5'd0, 16'h8A01, 1'b0, 1'b0, 1'b1);
    for (int c = 5; c <= 8; c++) ex[c] = e(9'd5, 1'b1, 5'd3, 16'h8B03, 1'b0, 1'b0, 1'b1);
    ex[9]  = e(9'd5, 1'b1, 5'd23, 16'h8C17, 1'b1, 1'b0, 1'b1);
    ex[10] = e(9'd5, 1'b0, 5'd0,  16'd0,    1'b0, 1'b1, 1'b1);
    ex[11] = e(9'd5, 1'b0, 5'd0,  16'd0,    1'b0, 1'b0, 1'b0);
    push(mk_phv(9'h005, 24'h000BBB));
    for (int c = 1; c <= 11; c++) begin
      @(negedge axis_clk);
      checks++;
      if (obs() !== ex[c]) begin errors++; $display("FAIL backpressure cyc%0d got %h exp %h", c, obs(), ex[c]); end
      i_act_ready = rdy[c];
    end
    i_act_ready = 1'b1;
  endtask

  task automatic test_zero_slots();
    logic [33:0] ex [1:5];
    for (int c = 1; c <= 3; c++) ex[c] = e(9'd7, 1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    ex[4] = e(9'd7, 1'b0, 5'd0, 16'd0, 1'b0, 1'b1, 1'b1);
    ex[5] = e(9'd7, 1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0);
    push(mk_phv(9'h007, 24'h000777));
    for (int c = 1; c <= 5; c++) begin
      @(negedge axis_clk);
      checks++;
      if (obs() !== ex[c]) begin errors++; $display("FAIL zero_slots cyc%0d got %h exp %h", c, obs(), ex[c]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] ex [1:14];
    logic [1123:0] pb;
    pb = mk_phv(9'h002, 24'h0000B2);
    for (int c = 1; c <= 3; c++) ex[c] = e(9'd1, 1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    ex[4] = e(9'd1, 1'b1, 5'd2,  16'h8222, 1'b0, 1'b0, 1'b1);
    ex[5] = e(9'd1, 1'b1, 5'd10, 16'hC00A, 1'b1, 1'b0, 1'b1);
    ex[6] = e(9'd1, 1'b0, 5'd0,  16'd0,    1'b0, 1'b1, 1'b1);
    ex[7] = e(9'd1, 1'b0, 5'd0,  16'd0,    1'b0, 1'b0, 1'b0);
    for (int c = 8; c <= 10; c++) ex[c] = e(9'd2, 1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    ex[11] = e(9'd2, 1'b1, 5'd0,  16'hFFFF, 1'b0, 1'b0, 1'b1);
    ex[12] = e(9'd2, 1'b1, 5'd23, 16'h8017, 1'b1, 1'b0, 1'b1);
    ex[13] = e(9'd2, 1'b0, 5'd0,  16'd0,    1'b0, 1'b1, 1'b1);
    ex[14] = e(9'd2, 1'b0, 5'd0,  16'd0,    1'b0, 1'b0, 1'b0);
    push(mk_phv(9'h001, 24'h0000A1));
    push(pb);
    for (int c = 1; c <= 14; c++) begin
      @(negedge axis_clk);
      checks++;
      if (obs() !== ex[c]) begin errors++; $display("FAIL back_to_back cyc%0d got %h exp %h", c, obs(), ex[c]); end
    end
    checks++;
    if (o_phv !== pb) begin errors++; $display("FAIL b2b_phv got %h exp %h", o_phv[1123:1100], pb[1123:1100]); end
  endtask

  task automatic test_reset_mid();
    logic [33:0] ex [1:8];
    for (int c = 1; c <= 3; c++) ex[c] = e(9'd9, 1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    ex[4] = e(9'd9, 1'b1, 5'd0,  16'h8A01, 1'b0, 1'b0, 1'b1);
    ex[5] = e(9'd9, 1'b1, 5'd3,  16'h8B03, 1'b0, 1'b0, 1'b1);
    ex[6] = e(9'd9, 1'b1, 5'd23, 16'h8C17, 1'b1, 1'b0, 1'b1);
    ex[7] = e(9'd9, 1'b0, 5'd0,  16'd0,    1'b0, 1'b1, 1'b1);
    ex[8] = e(9'd9, 1'b0, 5'd0,  16'd0,    1'b0, 1'b0, 1'b0);
    push(mk_phv(9'h009, 24'h000999));
    for (int c = 1; c <= 5; c++) begin
      @(negedge axis_clk);
      checks++;
      if (obs() !== ex[c]) begin errors++; $display("FAIL reset_mid_pre cyc%0d got %h exp %h", c, obs(), ex[c]); end
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if ({obs(), o_act_idx, o_act_data} !== {e(9'd0, 1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0), 21'd0} || o_phv !== '0)
      begin errors++; $display("FAIL reset_mid_async got %h idx %0d data %h", obs(), o_act_idx, o_act_data); end
    for (int c = 0; c < 2; c++) begin
      @(negedge axis_clk);
      checks++;
      if ({o_phv_fifo_rd_en, i_phv_fifo_empty_n} !== 2'b01)
        begin errors++; $display("FAIL reset_mid_no_pop got rd_en %b empty_n %b exp 0 1", o_phv_fifo_rd_en, i_phv_fifo_empty_n); end
    end
    aresetn = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge axis_clk);
      checks++;
      if (obs() !== ex[c]) begin errors++; $display("FAIL reset_mid_replay cyc%0d got %h exp %h", c, obs(), ex[c]); end
    end
  endtask

  task automatic test_config_rewrite();
    logic [33:0] ex [1:8];
    for (int c = 1; c <= 3; c++) ex[c] = e(9'd11, 1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b1);
    ex[4] = e(9'd11, 1'b1, 5'd0,  16'h8A01, 1'b0, 1'b0, 1'b1);
    ex[5] = e(9'd11, 1'b1, 5'd3,  16'h8B03, 1'b0, 1'b0, 1'b1);
    ex[6] = e(9'd11, 1'b1, 5'd23, 16'h8C17, 1'b1, 1'b0, 1'b1);
    ex[7] = e(9'd11, 1'b0, 5'd0,  16'd0,    1'b0, 1'b1, 1'b1);
    ex[8] = e(9'd11, 1'b0, 5'd0,  16'd0,    1'b0, 1'b0, 1'b0);
    push(mk_phv(9'h00B, 24'h000CCC));
    for (int c = 1; c <= 8; c++) begin
      @(negedge axis_clk);
      checks++;
      if (obs() !== ex[c]) begin errors++; $display("FAIL config_rewrite cyc%0d got %h exp %h", c, obs(), ex[c]); end
      if (c == 4) mem[11] = w_new;
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    w1 = '0;
    w1 = put(w1, 0, 16'h8A01);
    w1 = put(w1, 3, 16'h8B03);
    w1 = put(w1, 5, 16'h7FFF);
    w1 = put(w1, 23, 16'h8C17);
    w_zero = '0;
    w_zero = put(w_zero, 1, 16'h7123);
    w_zero = put(w_zero, 23, 16'h0001);
    w_a = '0;
    w_a = put(w_a, 2, 16'h8222);
    w_a = put(w_a, 10, 16'hC00A);
    w_a = put(w_a, 11, 16'h1234);
    w_b = '0;
    w_b = put(w_b, 0, 16'hFFFF);
    w_b = put(w_b, 23, 16'h8017);
    w_new = '0;
    w_new = put(w_new, 3, 16'h9999);
    w_new = put(w_new, 4, 16'h8004);
    w_new = put(w_new, 23, 16'h9A17);
    mem[5] = w1; mem[7] = w_zero; mem[1] = w_a; mem[2] = w_b; mem[9] = w1; mem[11] = w1;

    test_reset();
    test_single();
    test_backpressure();
    test_zero_slots();
    test_back_to_back();
    test_reset_mid();
    test_config_rewrite();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
